// File: rtl/prach_hb1_pp.sv
// Polyphase packer ahead of the 16-channel PRACH hb1 decimator: pairs each channel's even/odd
// TDM samples onto dp2/dp1. Define PRACH_HB1_PP_CHN_CHECK_EN to enable the din_chn sticky check.
module prach_hb1_pp #(
  parameter int unsigned NUM_CHANNEL = 16,
  parameter int unsigned DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_dq,
  input  logic              din_dv,
  input  logic [7:0]        din_chn,
  input  logic              sync_in,
  output logic [DATA_W-1:0] dout_dp1,
  output logic [DATA_W-1:0] dout_dp2,
  output logic              dout_dv,
  output logic [7:0]        dout_chn,
  output logic              sync_out,
  output logic              err
);

  localparam int unsigned ChnW = $clog2(NUM_CHANNEL);

  typedef enum logic [0:0] {StEven, StOdd} phase_e;

  phase_e          phase_q, phase_d;
  logic [ChnW-1:0] ecnt_q, ecnt_d;
  logic            armed_q, armed_d;
  logic            synced_q, synced_d;

  logic            force_sync;
  phase_e          cur_phase;
  logic [ChnW-1:0] cur_cnt;
  logic            last_chn;
  logic            wr_en;
  logic            rd_en;
  logic            pair_sync;

  // A pending or present sync overrides the tracked position for this sample.
  always_comb begin
    force_sync = sync_in | armed_q;
    cur_phase  = force_sync ? StEven : phase_q;
    cur_cnt    = force_sync ? '0 : ecnt_q;
    last_chn   = (cur_cnt == ChnW'(NUM_CHANNEL - 1));
    wr_en      = din_dv & (cur_phase == StEven);
    rd_en      = din_dv & (cur_phase == StOdd);
    pair_sync  = synced_q & (cur_cnt == '0);
  end

  always_comb begin
    phase_d  = phase_q;
    ecnt_d   = ecnt_q;
    armed_d  = armed_q;
    synced_d = synced_q;
    if (din_dv) begin
      armed_d = 1'b0;
      phase_d = cur_phase;
      ecnt_d  = cur_cnt + ChnW'(1);
      if (force_sync) begin
        synced_d = 1'b1;
      end else if (rd_en && (cur_cnt == '0)) begin
        synced_d = 1'b0;
      end
      if (last_chn) begin
        ecnt_d  = '0;
        phase_d = (cur_phase == StEven) ? StOdd : StEven;
      end
    end else if (sync_in) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= StEven;
      ecnt_q   <= '0;
      armed_q  <= 1'b0;
      synced_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      ecnt_q   <= ecnt_d;
      armed_q  <= armed_d;
      synced_q <= synced_d;
    end
  end

  logic [DATA_W-1:0] ram_q [NUM_CHANNEL];

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      ram_q[cur_cnt] <= din_dq;
    end
  end

  logic              s1_vld_q, s1_sync_q;
  logic [ChnW-1:0]   s1_chn_q;
  logic [DATA_W-1:0] s1_even_q, s1_odd_q;
  logic              out_dv_q, out_sync_q;
  logic [7:0]        out_chn_q;
  logic [DATA_W-1:0] out_dp1_q, out_dp2_q;

  // Stage 1 is the registered RAM read; stage 2 is the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_sync_q  <= 1'b0;
      s1_chn_q   <= '0;
      s1_even_q  <= '0;
      s1_odd_q   <= '0;
      out_dv_q   <= 1'b0;
      out_sync_q <= 1'b0;
      out_chn_q  <= '0;
      out_dp1_q  <= '0;
      out_dp2_q  <= '0;
    end else begin
      s1_vld_q   <= rd_en;
      s1_sync_q  <= rd_en & pair_sync;
      if (rd_en) begin
        s1_chn_q  <= cur_cnt;
        s1_even_q <= ram_q[cur_cnt];
        s1_odd_q  <= din_dq;
      end
      out_dv_q   <= s1_vld_q;
      out_sync_q <= s1_sync_q;
      if (s1_vld_q) begin
        out_chn_q <= 8'(s1_chn_q);
        out_dp1_q <= s1_odd_q;
        out_dp2_q <= s1_even_q;
      end
    end
  end

  assign dout_dv  = out_dv_q;
  assign sync_out = out_sync_q;
  assign dout_chn = out_chn_q;
  assign dout_dp1 = out_dp1_q;
  assign dout_dp2 = out_dp2_q;

`ifdef PRACH_HB1_PP_CHN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (din_dv && (din_chn != 8'(cur_cnt))) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_chn;
  assign unused_chn = ^din_chn;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_prach_hb1_pp.sv
// Bench for prach_hb1_pp: directed vector table, hand sequences and random stimulus checked
// against a cycle-scheduled behavioural model of the even/odd pairing rules.
module tb_prach_hb1_pp;

  localparam int unsigned NCH = 16;
  localparam int unsigned DW  = 16;
`ifdef PRACH_HB1_PP_CHN_CHECK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din_dq = '0;
  logic          din_dv = 1'b0;
  logic [7:0]    din_chn = '0;
  logic          sync_in = 1'b0;
  logic [DW-1:0] dout_dp1, dout_dp2;
  logic          dout_dv, sync_out, err;
  logic [7:0]    dout_chn;

  prach_hb1_pp #(.NUM_CHANNEL(NCH), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_dq   (din_dq),
    .din_dv   (din_dv),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dp1 (dout_dp1),
    .dout_dp2 (dout_dp2),
    .dout_dv  (dout_dv),
    .dout_chn (dout_chn),
    .sync_out (sync_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Model: position in the period plus a ring of outputs scheduled by visible cycle.
  int            m_phase, m_cnt;
  bit            m_armed, m_psync;
  logic [DW-1:0] m_even [NCH];
  bit            s_vld [8], s_sync [8], s_rst [8], s_err [8];
  logic [DW-1:0] s_dp1 [8], s_dp2 [8];
  logic [7:0]    s_chn [8];
  logic [DW-1:0] e_dp1, e_dp2;
  logic [7:0]    e_chn;
  bit            e_dv, e_sync, e_err;

  int cyc = 0;
  bit started = 1'b0;
  bit gap_mode = 1'b0;
  int dv_seen = 0, sync_seen = 0;
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit rst, input bit dv, input logic [DW-1:0] dq, input bit sy,
                      input logic [7:0] ch);
    int c0, c1, c2;
    @(posedge clk);
    #1;
    rst_n = !rst; din_dv = dv; din_dq = dq; sync_in = sy; din_chn = ch;
    c1 = (cyc + 1) % 8;
    c2 = (cyc + 2) % 8;
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_armed = 0; m_psync = 0;
      s_vld[c1] = 0; s_vld[c2] = 0; s_err[c1] = 0; s_rst[c1] = 1;
    end else if (dv) begin
      if (sy || m_armed) begin
        m_phase = 0; m_cnt = 0; m_psync = 1; m_armed = 0;
      end
      if (ChkEn && (ch != 8'(m_cnt))) s_err[c1] = 1;
      if (m_phase == 0) begin
        m_even[m_cnt] = dq;
      end else begin
        s_vld[c2]  = 1;
        s_dp2[c2]  = m_even[m_cnt];
        s_dp1[c2]  = dq;
        s_chn[c2]  = 8'(m_cnt);
        s_sync[c2] = m_psync && (m_cnt == 0);
      end
      if (m_cnt == NCH - 1) begin
        if (m_phase == 1) m_psync = 0;
        m_cnt   = 0;
        m_phase = 1 - m_phase;
      end else begin
        m_cnt++;
      end
    end else if (sy) begin
      m_armed = 1;
    end
    @(negedge clk);
    c0 = cyc % 8;
    if (s_rst[c0]) begin
      e_dp1 = '0; e_dp2 = '0; e_chn = '0; e_err = 0;
    end
    e_dv   = s_vld[c0];
    e_sync = s_vld[c0] && s_sync[c0];
    if (s_vld[c0]) begin
      e_dp1 = s_dp1[c0]; e_dp2 = s_dp2[c0]; e_chn = s_chn[c0];
    end
    if (s_err[c0]) e_err = 1;
    s_rst[c0] = 0; s_vld[c0] = 0; s_err[c0] = 0;
    if (started) begin
      chk("dout_dv", 32'(dout_dv), 32'(e_dv));
      chk("sync_out", 32'(sync_out), 32'(e_sync));
      chk("err", 32'(err), 32'(e_err));
      chk("dout_dp1", 32'(dout_dp1), 32'(e_dp1));
      chk("dout_dp2", 32'(dout_dp2), 32'(e_dp2));
      chk("dout_chn", 32'(dout_chn), 32'(e_chn));
    end
    if (dout_dv === 1'b1) dv_seen++;
    if (sync_out === 1'b1) sync_seen++;
    started = 1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0);
  endtask

  task automatic send(input logic [DW-1:0] dq, input int ch, input bit sy);
    if (gap_mode && (cyc % 3 == 2)) step(0, 0, '0, 0, '0);
    step(0, 1, dq, sy, 8'(ch));
  endtask

  // phase 0 sends 0x0100+ch, phase 1 sends 0x0200+ch.
  task automatic frame(input int ph, input int first, input int last, input bit sy);
    for (int ch = first; ch <= last; ch++) begin
      send(16'((ph == 0 ? 16'h0100 : 16'h0200) + ch), ch, sy && (ch == first));
    end
  endtask

  typedef struct {
    bit            dv;
    bit            sy;
    logic [DW-1:0] dq;
    logic [7:0]    ch;
    bit            x_dv;
    bit            x_sync;
    logic [7:0]    x_chn;
    logic [DW-1:0] x_dp1;
    logic [DW-1:0] x_dp2;
  } vec_t;

  vec_t tbl [34];

  initial begin
    int dv0, sy0, k;
    logic [7:0] hch;
    logic [DW-1:0] hd1, hd2, rdq;
    bit rr, rs, rv;
    logic [7:0] rc;

    hch = '0; hd1 = '0; hd2 = '0;
    for (int i = 0; i < 34; i++) begin
      tbl[i].dv = (i < 32);
      tbl[i].sy = (i == 0);
      tbl[i].dq = (i < 16) ? 16'(16'h0100 + i) : ((i < 32) ? 16'(16'h0200 + i - 16) : '0);
      tbl[i].ch = 8'(i % 16);
      k = i - 2;
      if (k >= 16 && k < 32) begin
        hch = 8'(k - 16); hd2 = 16'(16'h0100 + k - 16); hd1 = 16'(16'h0200 + k - 16);
        tbl[i].x_dv = 1; tbl[i].x_sync = (k == 16);
      end else begin
        tbl[i].x_dv = 0; tbl[i].x_sync = 0;
      end
      tbl[i].x_chn = hch; tbl[i].x_dp1 = hd1; tbl[i].x_dp2 = hd2;
    end

    step(1, 0, '0, 0, '0);
    step(1, 0, '0, 0, '0);

    // One synced period, continuous valid, against the hand-derived table.
    for (int i = 0; i < 34; i++) begin
      step(0, tbl[i].dv, tbl[i].dq, tbl[i].sy, tbl[i].ch);
      chk("tbl_dv", 32'(dout_dv), 32'(tbl[i].x_dv));
      chk("tbl_sync", 32'(sync_out), 32'(tbl[i].x_sync));
      chk("tbl_chn", 32'(dout_chn), 32'(tbl[i].x_chn));
      chk("tbl_dp1", 32'(dout_dp1), 32'(tbl[i].x_dp1));
      chk("tbl_dp2", 32'(dout_dp2), 32'(tbl[i].x_dp2));
    end

    // Valid gaps every third cycle: two periods, 32 pairs, one sync pulse.
    gap_mode = 1;
    dv0 = dv_seen; sy0 = sync_seen;
    frame(0, 0, 15, 1); frame(1, 0, 15, 0);
    frame(0, 0, 15, 0); frame(1, 0, 15, 0);
    gap_mode = 0;
    idle(3);
    chk("gap_pairs", 32'(dv_seen - dv0), 32'd32);
    chk("gap_syncs", 32'(sync_seen - sy0), 32'd1);

    // Sync at even ch 5 of the second period discards it.
    frame(0, 0, 15, 1); frame(1, 0, 15, 0);
    idle(3);
    dv0 = dv_seen; sy0 = sync_seen;
    frame(0, 0, 4, 0);
    chk("broken_pairs", 32'(dv_seen - dv0), 32'd0);
    frame(0, 0, 15, 1); frame(1, 0, 15, 0);
    idle(3);
    chk("restart_pairs", 32'(dv_seen - dv0), 32'd16);
    chk("restart_syncs", 32'(sync_seen - sy0), 32'd1);

    // Armed sync while idle, from mid-period.
    frame(0, 0, 2, 0);
    dv0 = dv_seen; sy0 = sync_seen;
    step(0, 0, '0, 1, '0);
    idle(4);
    frame(0, 0, 15, 0); frame(1, 0, 15, 0);
    idle(3);
    chk("armed_pairs", 32'(dv_seen - dv0), 32'd16);
    chk("armed_syncs", 32'(sync_seen - sy0), 32'd1);

    // Channel mismatch at ch 2.
    frame(0, 0, 1, 1);
    step(0, 1, 16'h0102, 0, 8'd3);
    chk("err_next", 32'(err), 32'(ChkEn));
    frame(0, 3, 15, 0); frame(1, 0, 15, 0);
    idle(3);
    chk("err_sticky", 32'(err), 32'(ChkEn));

    // Reset during odd ch 9.
    frame(0, 0, 15, 1); frame(1, 0, 8, 0);
    step(1, 1, 16'h0209, 0, 8'd9);
    step(0, 0, '0, 0, '0);
    chk("rst_dv", 32'(dout_dv), 32'd0);
    chk("rst_dp1", 32'(dout_dp1), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    idle(2);
    dv0 = dv_seen;
    frame(0, 0, 15, 1); frame(1, 0, 15, 0);
    idle(3);
    chk("post_rst_pairs", 32'(dv_seen - dv0), 32'd16);

    // Random traffic with occasional sync, bad channel and reset.
    for (int n = 0; n < 1500; n++) begin
      rr  = ($urandom_range(0, 999) < 4);
      rs  = ($urandom_range(0, 99) < 2);
      rv  = ($urandom_range(0, 9) < 7);
      rdq = DW'($urandom);
      rc  = (rs || m_armed) ? 8'd0 : 8'(m_cnt);
      if ($urandom_range(0, 99) < 3) rc = 8'($urandom);
      step(rr, rv, rdq, rs, rc);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
